// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER data-port arbiter.
package otter_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_DATA = 1'b1
  } state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'd0;
  localparam logic [1:0]  SZ_HALF   = 2'd1;
  localparam logic [1:0]  SZ_WORD   = 2'd2;
  localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

endpackage

// File: rtl/otter_arb_pick.sv
// Combinational winner select: R0 priority unless R1 has waited STARVE_LIMIT grants.
module otter_arb_pick #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [3:0] starve_cnt_i,
  output logic [1:0] gnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  always_comb begin
    gnt_o = 2'b00;
    if (req0_i && req1_i) begin
      gnt_o = (starve_cnt_i == LIMIT) ? 2'b10 : 2'b01;
    end else if (req0_i) begin
      gnt_o = 2'b01;
    end else if (req1_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Shares the OTTER memory data port between the CPU (R0) and a secondary master (R1).
// Handshake: a requester holds REQ and attributes until GNT is high at a rising edge.
module otter_dmem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        R0_REQ,
  input  logic        R0_WE,
  input  logic [31:0] R0_ADDR,
  input  logic [31:0] R0_DIN,
  input  logic [1:0]  R0_SIZE,
  input  logic        R0_SIGN,
  output logic        R0_GNT,
  output logic        R0_RVALID,
  output logic [31:0] R0_DOUT,
  input  logic        R1_REQ,
  input  logic        R1_WE,
  input  logic [31:0] R1_ADDR,
  input  logic [31:0] R1_DIN,
  input  logic [1:0]  R1_SIZE,
  input  logic        R1_SIGN,
  output logic        R1_GNT,
  output logic        R1_RVALID,
  output logic [31:0] R1_DOUT,
  output logic        MEM_RDEN2,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2,
  output state_t      DBG_STATE
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [3:0]  starve_q, starve_d;

  logic [1:0]  pick_gnt;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_din;
  logic [1:0]  sel_size;
  logic        sel_sign;

  otter_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .req0_i      (R0_REQ),
    .req1_i      (R1_REQ),
    .starve_cnt_i(starve_q),
    .gnt_o       (pick_gnt)
  );

  assign sel      = pick_gnt[1];
  assign sel_we   = sel ? R1_WE   : R0_WE;
  assign sel_addr = sel ? R1_ADDR : R0_ADDR;
  assign sel_din  = sel ? R1_DIN  : R0_DIN;
  assign sel_size = sel ? R1_SIZE : R0_SIZE;
  assign sel_sign = sel ? R1_SIGN : R0_SIGN;

  // Read data is sized by the memory from the address it sees, so no mux here.
  assign R0_DOUT   = MEM_DOUT2;
  assign R1_DOUT   = MEM_DOUT2;
  assign DBG_STATE = state_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sign_d    = sign_q;
    starve_d  = starve_q;
    R0_GNT    = 1'b0;
    R1_GNT    = 1'b0;
    R0_RVALID = 1'b0;
    R1_RVALID = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    MEM_ADDR2 = 32'h0;
    MEM_DIN2  = 32'h0;
    MEM_SIZE  = 2'b00;
    MEM_SIGN  = 1'b0;
    // Outputs are forced quiet for the whole time reset is held.
    if (!RST) begin
      case (state_q)
        IDLE: begin
          R0_GNT = pick_gnt[0];
          R1_GNT = pick_gnt[1];
          if (|pick_gnt) begin
            MEM_WE2   = sel_we;
            MEM_RDEN2 = !sel_we;
            MEM_ADDR2 = sel_addr;
            MEM_DIN2  = sel_din;
            MEM_SIZE  = sel_size;
            MEM_SIGN  = sel_sign;
            if (!sel_we) begin
              state_d = RD_DATA;
              owner_d = sel;
              addr_d  = sel_addr;
              size_d  = sel_size;
              sign_d  = sel_sign;
            end
          end
          if (!R1_REQ || pick_gnt[1]) begin
            starve_d = 4'd0;
          end else if (pick_gnt[0] && (starve_q != LIMIT)) begin
            starve_d = starve_q + 4'd1;
          end
        end
        RD_DATA: begin
          MEM_ADDR2 = addr_q;
          MEM_SIZE  = size_q;
          MEM_SIGN  = sign_q;
          R0_RVALID = !owner_q;
          R1_RVALID = owner_q;
          state_d   = IDLE;
          if (!R1_REQ) begin
            starve_d = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      sign_q   <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Bench for otter_dmem_arbiter with a byte-addressed memory/IO model and a port-occupancy model.
module tb_otter_dmem_arbiter;
  import otter_arb_pkg::*;

  localparam int LIMIT = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        r0_req = 0, r0_we = 0, r0_sign = 0;
  logic [31:0] r0_addr = 0, r0_din = 0;
  logic [1:0]  r0_size = 0;
  logic        r1_req = 0, r1_we = 0, r1_sign = 0;
  logic [31:0] r1_addr = 0, r1_din = 0;
  logic [1:0]  r1_size = 0;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_dout, r1_dout;
  logic        mem_rden2, mem_we2, mem_sign;
  logic [31:0] mem_addr2, mem_din2, mem_dout2;
  logic [1:0]  mem_size;
  state_t      dbg_state;
  logic [31:0] io_in = 32'h0;

  otter_dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(clk), .RST(rst),
    .R0_REQ(r0_req), .R0_WE(r0_we), .R0_ADDR(r0_addr), .R0_DIN(r0_din),
    .R0_SIZE(r0_size), .R0_SIGN(r0_sign), .R0_GNT(r0_gnt), .R0_RVALID(r0_rvalid), .R0_DOUT(r0_dout),
    .R1_REQ(r1_req), .R1_WE(r1_we), .R1_ADDR(r1_addr), .R1_DIN(r1_din),
    .R1_SIZE(r1_size), .R1_SIGN(r1_sign), .R1_GNT(r1_gnt), .R1_RVALID(r1_rvalid), .R1_DOUT(r1_dout),
    .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .MEM_ADDR2(mem_addr2), .MEM_DIN2(mem_din2),
    .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign), .MEM_DOUT2(mem_dout2), .DBG_STATE(dbg_state)
  );

  // memory model: synchronous word read, combinational sizing from current address/size/sign
  logic [7:0]  mem [0:4095];
  logic [31:0] word_q = 32'h0;

  always @(posedge clk) begin
    if (mem_rden2) begin
      word_q <= {mem[{mem_addr2[11:2], 2'b11}], mem[{mem_addr2[11:2], 2'b10}],
                 mem[{mem_addr2[11:2], 2'b01}], mem[{mem_addr2[11:2], 2'b00}]};
    end
    if (mem_we2 && mem_addr2 < MMIO_BASE) begin
      mem[mem_addr2[11:0]] <= mem_din2[7:0];
      if (mem_size != SZ_BYTE) mem[mem_addr2[11:0] + 12'd1] <= mem_din2[15:8];
      if (mem_size == SZ_WORD) begin
        mem[mem_addr2[11:0] + 12'd2] <= mem_din2[23:16];
        mem[mem_addr2[11:0] + 12'd3] <= mem_din2[31:24];
      end
    end
  end

  function automatic logic [31:0] size_data(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    s = w >> (8 * a[1:0]);
    case (sz)
      SZ_BYTE: return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      SZ_HALF: return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: return w;
    endcase
  endfunction

  assign mem_dout2 = (mem_addr2 >= MMIO_BASE) ? io_in : size_data(word_q, mem_addr2, mem_size, mem_sign);

  // scoreboard
  int total = 0;
  int bad = 0;
  int io_wr_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // port model: a read occupies the port for its data cycle; R1 wins once it has lost LIMIT times in a row
  bit          m_busy = 0;
  bit          m_owner = 0;
  logic [31:0] m_addr = 0;
  logic [1:0]  m_size = 0;
  bit          m_sign = 0;
  int          m_streak = 0;

  always @(negedge clk) begin
    logic [1:0]  e_gnt, e_rv, e_size;
    logic        e_we, e_rd, e_sign, w_we;
    logic [31:0] e_addr, e_din;
    int          win;
    e_gnt = 0; e_rv = 0; e_we = 0; e_rd = 0; e_addr = 0; e_din = 0; e_size = 0; e_sign = 0;
    win = -1;
    if (rst) begin
      m_busy = 0;
      m_streak = 0;
    end else if (m_busy) begin
      e_rv[m_owner] = 1'b1;
      e_addr = m_addr; e_size = m_size; e_sign = m_sign;
      m_busy = 0;
      if (!r1_req) m_streak = 0;
    end else begin
      if (r0_req && r1_req) win = (m_streak == LIMIT) ? 1 : 0;
      else if (r0_req) win = 0;
      else if (r1_req) win = 1;
      if (win >= 0) begin
        e_gnt[win] = 1'b1;
        w_we   = (win == 1) ? r1_we   : r0_we;
        e_we   = w_we;
        e_rd   = !w_we;
        e_addr = (win == 1) ? r1_addr : r0_addr;
        e_din  = (win == 1) ? r1_din  : r0_din;
        e_size = (win == 1) ? r1_size : r0_size;
        e_sign = (win == 1) ? r1_sign : r0_sign;
        if (!w_we) begin
          m_busy = 1; m_owner = (win == 1); m_addr = e_addr; m_size = e_size; m_sign = e_sign;
        end
      end
      if (!r1_req || win == 1) m_streak = 0;
      else if (win == 0 && m_streak < LIMIT) m_streak++;
    end
    chk("gnt", {30'h0, r1_gnt, r0_gnt}, {30'h0, e_gnt});
    chk("rvalid", {30'h0, r1_rvalid, r0_rvalid}, {30'h0, e_rv});
    chk("mem_we2", {31'h0, mem_we2}, {31'h0, e_we});
    chk("mem_rden2", {31'h0, mem_rden2}, {31'h0, e_rd});
    chk("mem_addr2", mem_addr2, e_addr);
    chk("mem_din2", mem_din2, e_din);
    chk("mem_size", {30'h0, mem_size}, {30'h0, e_size});
    chk("mem_sign", {31'h0, mem_sign}, {31'h0, e_sign});
    chk("r0_dout_pass", r0_dout, mem_dout2);
    chk("r1_dout_pass", r1_dout, mem_dout2);
    if (r0_rvalid || r1_rvalid) begin
      if (exp_q.size() == 0) chk("unexpected_rvalid", 32'h1, 32'h0);
      else chk("read_data", r0_rvalid ? r0_dout : r1_dout, exp_q.pop_front());
    end
    if (!rst && mem_we2 && mem_addr2 >= MMIO_BASE) io_wr_cnt++;
  end

  // driver tasks
  task automatic set_req(input int id, input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz, input logic sg);
    if (id == 0) begin r0_req = 1; r0_we = we; r0_addr = a; r0_din = d; r0_size = sz; r0_sign = sg; end
    else begin r1_req = 1; r1_we = we; r1_addr = a; r1_din = d; r1_size = sz; r1_sign = sg; end
  endtask

  task automatic access(input int id, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic sg);
    bit ok;
    @(posedge clk); #1;
    set_req(id, we, a, d, sz, sg);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id == 0 && r0_gnt) || (id == 1 && r1_gnt)) begin ok = 1; break; end
    end
    chk("grant_timeout", {31'h0, ok}, 32'h1);
    @(posedge clk); #1;
    if (id == 0) r0_req = 0; else r1_req = 0;
    if (!we) @(negedge clk);
  endtask

  logic [1:0] pat [10];
  logic [1:0] seen [10];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h0;
    {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} = 32'hDEADBEEF;
    pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", {30'h0, r1_gnt, r0_gnt}, 32'h0);
    chk("reset_addr", mem_addr2, 32'h0);
    @(posedge clk); #1 rst = 0;

    // R0 word read at 0x100
    exp_q.push_back(32'hDEADBEEF);
    @(posedge clk); #1 set_req(0, 0, 32'h100, 32'h0, SZ_WORD, 0);
    @(negedge clk);
    chk("t1_gnt", {31'h0, r0_gnt}, 32'h1);
    chk("t1_addr_n", mem_addr2, 32'h100);
    @(posedge clk); #1 r0_req = 0;
    @(negedge clk);
    chk("t1_rvalid", {30'h0, r1_rvalid, r0_rvalid}, 32'h1);
    chk("t1_dout", r0_dout, 32'hDEADBEEF);
    chk("t1_addr_n1", mem_addr2, 32'h100);

    // R1 byte reads at 0x103, signed then unsigned
    exp_q.push_back(32'hFFFFFFDE);
    access(1, 0, 32'h103, 32'h0, SZ_BYTE, 0);
    chk("t2_signed", r1_dout, 32'hFFFFFFDE);
    exp_q.push_back(32'h000000DE);
    access(1, 0, 32'h103, 32'h0, SZ_BYTE, 1);
    chk("t2_unsigned", r1_dout, 32'h000000DE);
    exp_q.push_back(32'hFFFFBEEF);
    access(0, 0, 32'h100, 32'h0, SZ_HALF, 0);

    // both masters writing continuously: starvation pattern
    @(posedge clk); #1;
    set_req(0, 1, 32'h200, 32'h11111111, SZ_WORD, 0);
    set_req(1, 1, 32'h300, 32'h22222222, SZ_WORD, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen[i] = {r1_gnt, r0_gnt};
      chk("t3_we", {31'h0, mem_we2}, 32'h1);
      @(posedge clk); #1;
    end
    r0_req = 0; r1_req = 0;
    for (int i = 0; i < 10; i++) chk("t3_pattern", {30'h0, seen[i]}, {30'h0, pat[i]});

    // R1 write arriving during R0 read data cycle waits one cycle
    exp_q.push_back(32'hDEADBEEF);
    @(posedge clk); #1 set_req(0, 0, 32'h100, 32'h0, SZ_WORD, 0);
    @(negedge clk);
    chk("t4_r0_gnt", {31'h0, r0_gnt}, 32'h1);
    @(posedge clk); #1 r0_req = 0;
    set_req(1, 1, 32'h100, 32'hCAFEF00D, SZ_WORD, 0);
    @(negedge clk);
    chk("t4_no_gnt", {31'h0, r1_gnt}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_r1_gnt", {31'h0, r1_gnt}, 32'h1);
    chk("t4_we", {31'h0, mem_we2}, 32'h1);
    @(posedge clk); #1 r1_req = 0;
    exp_q.push_back(32'hCAFEF00D);
    access(0, 0, 32'h100, 32'h0, SZ_WORD, 0);
    chk("t4_readback", mem_dout2, 32'hCAFEF00D);

    // reset during RD_DATA drops the read
    @(posedge clk); #1 set_req(0, 0, 32'h104, 32'h0, SZ_WORD, 0);
    @(negedge clk);
    chk("t5_gnt", {31'h0, r0_gnt}, 32'h1);
    @(posedge clk); #1 rst = 1;
    set_req(0, 0, 32'h100, 32'h0, SZ_WORD, 0);
    @(negedge clk);
    chk("t5_rst_rvalid", {31'h0, r0_rvalid}, 32'h0);
    chk("t5_rst_gnt", {31'h0, r0_gnt}, 32'h0);
    chk("t5_rst_rden", {31'h0, mem_rden2}, 32'h0);
    exp_q.push_back(32'hCAFEF00D);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("t5_post_gnt", {31'h0, r0_gnt}, 32'h1);
    chk("t5_post_rvalid", {31'h0, r0_rvalid}, 32'h0);
    @(posedge clk); #1 r0_req = 0;
    @(negedge clk);
    chk("t5_post_dout", r0_dout, 32'hCAFEF00D);

    // MMIO read and write
    io_in = 32'h12345678;
    exp_q.push_back(32'h12345678);
    access(0, 0, 32'h11000, 32'h0, SZ_WORD, 0);
    chk("t6_io_read", r0_dout, 32'h12345678);
    io_wr_cnt = 0;
    access(0, 1, 32'h11000, 32'hA5A5A5A5, SZ_WORD, 0);
    repeat (3) @(negedge clk);
    chk("t6_io_wr_once", io_wr_cnt, 32'd1);

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
